// File: rtl/sig_dump_pkg.sv
// Shared types and constants for the compliance-run signature dump controller.
package sig_dump_pkg;

  typedef enum logic [2:0] {
    RUN,
    DRAIN,
    RD_REQ,
    RD_CAP,
    STREAM,
    DONE
  } state_e;

  localparam int          WORD_BYTES          = 4;
  localparam logic [15:0] DEFAULT_TOHOST_ADDR = 16'h1000;

endpackage

// File: rtl/sig_watchdog.sv
// Enabled cycle counter that pulses hit_o on the TERM-th enabled cycle.
module sig_watchdog #(
  parameter int TERM  = 200,
  parameter int CNT_W = $clog2(TERM + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TERM - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit_o = en_i && !clr_i && (count_q == LAST);

endmodule

// File: rtl/sig_dump_ctrl.sv
// Halts the core on a TOHOST store (or watchdog expiry), then streams the
// signature window out of DMEM one word at a time over valid/ready.
module sig_dump_ctrl
  import sig_dump_pkg::*;
#(
  parameter int                ADDR_W         = 16,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = DEFAULT_TOHOST_ADDR,
  parameter int                TIMEOUT_CYCLES = 200,
  parameter int                DRAIN_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic [DATA_W-1:0] snoop_wdata,
  input  logic [ADDR_W-1:0] sig_begin,
  input  logic [ADDR_W-1:0] sig_end,
  output logic              core_halt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic [DATA_W-1:0] sig_data,
  output logic              sig_last,
  output logic              done,
  output logic              timeout,
  output logic              pass
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, end_q, end_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d, last_q, last_d;
  logic              halt_q, halt_d, timeout_q, timeout_d, pass_q, pass_d;
  logic              in_run, in_drain, tohost_hit, wd_hit, drain_hit;
  logic [ADDR_W-1:0] ptr_next;

  assign in_run     = (state_q == RUN);
  assign in_drain   = (state_q == DRAIN);
  assign tohost_hit = in_run && snoop_we && (snoop_addr == TOHOST_ADDR);
  assign ptr_next   = ptr_q + ADDR_W'(WORD_BYTES);

  sig_watchdog #(.TERM(TIMEOUT_CYCLES)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr_i (1'b0),
    .en_i  (in_run),
    .hit_o (wd_hit)
  );

  sig_watchdog #(.TERM(DRAIN_CYCLES)) u_drain (
    .clk   (clk),
    .reset (reset),
    .clr_i (!in_drain),
    .en_i  (in_drain),
    .hit_o (drain_hit)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    end_d     = end_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    halt_d    = halt_q;
    timeout_d = timeout_q;
    pass_d    = pass_q;
    unique case (state_q)
      RUN: begin
        // A TOHOST store takes priority over a coincident watchdog expiry.
        if (tohost_hit) begin
          pass_d = (snoop_wdata == DATA_W'(1));
        end else if (wd_hit) begin
          timeout_d = 1'b1;
        end
        if (tohost_hit || wd_hit) begin
          ptr_d   = sig_begin;
          end_d   = sig_end;
          halt_d  = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_hit) begin
          state_d = (end_q <= ptr_q) ? DONE : RD_REQ;
        end
      end
      RD_REQ: state_d = RD_CAP;
      RD_CAP: begin
        data_d  = rd_data;
        valid_d = 1'b1;
        last_d  = (ptr_next >= end_q);
        state_d = STREAM;
      end
      STREAM: begin
        if (sig_ready) begin
          valid_d = 1'b0;
          ptr_d   = ptr_next;
          state_d = last_q ? DONE : RD_REQ;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      ptr_q     <= '0;
      end_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      halt_q    <= 1'b0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      end_q     <= end_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      halt_q    <= halt_d;
      timeout_q <= timeout_d;
      pass_q    <= pass_d;
    end
  end

  assign core_halt = halt_q;
  assign rd_en     = (state_q == RD_REQ);
  assign rd_addr   = ptr_q;
  assign sig_valid = valid_q;
  assign sig_data  = data_q;
  assign sig_last  = last_q;
  assign done      = (state_q == DONE);
  assign timeout   = timeout_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Bench for sig_dump_ctrl: DMEM responder, randomized snoop/ready traffic,
// and an expected-dump model built from trigger time and window contents.
module tb_sig_dump_ctrl;
  import sig_dump_pkg::*;

  localparam int          TIMEOUT = 200;
  localparam int          DRAIN   = 4;
  localparam logic [15:0] TOHOST  = 16'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        snoop_we = 1'b0;
  logic [15:0] snoop_addr = '0;
  logic [31:0] snoop_wdata = '0;
  logic [15:0] sig_begin = '0;
  logic [15:0] sig_end = '0;
  logic        core_halt, rd_en, sig_valid, sig_last, done, timeout, pass;
  logic [15:0] rd_addr;
  logic [31:0] rd_data = '0;
  logic        sig_ready = 1'b0;
  logic [31:0] sig_data;

  logic [31:0] mem [0:16383];
  int          n_assert = 0;
  int          n_fail = 0;
  string       cur_tag = "";

  always #5 clk = ~clk;

  sig_dump_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .snoop_we    (snoop_we),
    .snoop_addr  (snoop_addr),
    .snoop_wdata (snoop_wdata),
    .sig_begin   (sig_begin),
    .sig_end     (sig_end),
    .core_halt   (core_halt),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .sig_valid   (sig_valid),
    .sig_ready   (sig_ready),
    .sig_data    (sig_data),
    .sig_last    (sig_last),
    .done        (done),
    .timeout     (timeout),
    .pass        (pass)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", cur_tag, name, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {9'd0, core_halt, rd_en, rd_addr, sig_valid, sig_data, sig_last, done, timeout, pass};
  endfunction

  // Leaves the bench at a negedge with reset just released: that cycle is cycle 0.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; snoop_we = 1'b0; snoop_addr = '0; snoop_wdata = '0;
    sig_ready = 1'b0; rd_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outputs(), 64'd0);
    reset = 1'b0;
  endtask

  task automatic run_case(input string tag, input int store_cyc, input logic [31:0] store_val,
                          input logic [15:0] b, input logic [15:0] e,
                          input int hold_beat, input int abort_beat, input bit rnd_ready);
    int          trig, nwords, first_rd, rd_cnt, held;
    bit          exp_to, exp_pass, pend_v, hold_prev, seen_done;
    logic [13:0] pend_a;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic        got_last[$];

    cur_tag = tag;
    for (int a = int'(b); a < int'(e); a += 4) begin
      mem[a >> 2] = $urandom;
      exp_q.push_back(mem[a >> 2]);
    end
    nwords   = exp_q.size();
    exp_to   = !(store_cyc >= 0 && store_cyc < TIMEOUT);
    trig     = exp_to ? TIMEOUT - 1 : store_cyc;
    exp_pass = !exp_to && (store_val == 32'd1);

    sig_begin = b;
    sig_end   = e;
    do_reset();
    first_rd = -1; rd_cnt = 0; held = 0; pend_v = 1'b0; pend_a = '0;
    hold_prev = 1'b0; seen_done = 1'b0; prev_data = '0; prev_last = 1'b0;

    for (int cyc = 0; cyc < 1000; cyc++) begin
      rd_data = pend_v ? mem[pend_a] : $urandom;
      chk("core_halt", core_halt, 64'(cyc > trig));
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (hold_prev) begin
        chk("hold_valid", sig_valid, 1);
        chk("hold_data", sig_data, prev_data);
        chk("hold_last", sig_last, prev_last);
      end
      if (sig_valid) chk("rd_while_valid", rd_en, 0);
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        chk("rd_addr", rd_addr, b + 16'(4 * rd_cnt));
        rd_cnt++;
      end
      pend_v = rd_en;
      pend_a = rd_addr[15:2];

      if (sig_valid && got_q.size() == abort_beat) begin
        reset = 1'b1;
        sig_ready = 1'b1;
        @(negedge clk);
        chk("abort_outputs", all_outputs(), 64'd0);
        chk("abort_state", dut.state_q, RUN);
        return;
      end

      if (sig_valid && got_q.size() == hold_beat && held < 5) begin
        sig_ready = 1'b0;
        held++;
      end else begin
        sig_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (sig_valid && sig_ready) begin
        got_q.push_back(sig_data);
        got_last.push_back(sig_last);
      end
      hold_prev = sig_valid && !sig_ready;
      prev_data = sig_data;
      prev_last = sig_last;

      snoop_we = 1'b0; snoop_addr = 16'($urandom); snoop_wdata = $urandom;
      if (cyc == store_cyc) begin
        snoop_we = 1'b1; snoop_addr = TOHOST; snoop_wdata = store_val;
      end else if (cyc > trig && cyc % 7 == 0) begin
        snoop_we = 1'b1; snoop_addr = TOHOST; snoop_wdata = exp_pass ? 32'd0 : 32'd1;
      end else if ($urandom_range(0, 3) == 0) begin
        snoop_we = 1'b1;
        if (snoop_addr == TOHOST) snoop_addr = TOHOST + 16'd4;
      end
      @(negedge clk);
    end

    chk("done_seen", seen_done, 1);
    chk("n_beats", got_q.size(), nwords);
    for (int i = 0; i < nwords && i < got_q.size(); i++) begin
      chk("beat_data", got_q[i], exp_q[i]);
      chk("beat_last", got_last[i], 64'(i == nwords - 1));
    end
    chk("rd_count", rd_cnt, nwords);
    if (nwords > 0) chk("first_rd_cycle", first_rd, trig + 1 + DRAIN);
    chk("pass", pass, exp_pass);
    chk("timeout", timeout, exp_to);
    chk("done", done, 1);
  endtask

  initial begin
    run_case("t1_tohost",  50,  32'd1, 16'h2000, 16'h2010, -1, -1, 1'b0);
    run_case("t2_wdog",    -1,  32'd0, 16'h3000, 16'h3008, -1, -1, 1'b0);
    run_case("t3_stall",   20,  32'd1, 16'h2000, 16'h2010,  0, -1, 1'b0);
    run_case("t4_empty",   30,  32'd3, 16'h2000, 16'h2000, -1, -1, 1'b0);
    run_case("t5_tie",     199, 32'($urandom_range(0, 1)), 16'h4000, 16'h400C, -1, -1, 1'b1);
    run_case("t6_abort",   40,  32'd1, 16'h2000, 16'h2010, -1,  1, 1'b0);
    run_case("t6_rerun",   50,  32'd1, 16'h2000, 16'h2010, -1, -1, 1'b0);
    run_case("t7_top",     int'($urandom_range(0, 150)), 32'd1, 16'hFFF0, 16'hFFFC, -1, -1, 1'b1);
    run_case("t8_fail",    int'($urandom_range(0, 150)), 32'd2, 16'h0100, 16'h0118, -1, -1, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
